// File: rtl/board_io_pkg.sv
// Shared types and constants for the board I/O controller: reset sequencer
// states and the LED levels used for the in-reset blink pattern.
package board_io_pkg;

    typedef enum logic [1:0] {
        RST_HOLD        = 2'd0,
        RST_STRETCH_CNT = 2'd1,
        RUN             = 2'd2
    } seq_state_e;

    localparam logic LED_BLINK_ON  = 1'b1;
    localparam logic LED_BLINK_OFF = 1'b0;

endpackage

// File: rtl/board_io_ctrl_debounce_ch.sv
// One debounced input channel: 2-flop synchroniser, stability counter,
// accepted-level flop and a registered 0->1 pulse aligned with the level change.
module debounce_ch #(
    parameter int CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any reversal back to the stable level restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
            rise_d   = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons/switches, PLL-lock driven SoC reset
// sequencer with stretch, and LED drive that blinks while the SoC is in reset.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_BTN         = 1,
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_STRETCH     = 1024,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               pll_locked_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_LED-1:0] led_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] btn_rise_o,
    output logic [NUM_SW-1:0]  sw_o,
    output logic               soc_rst_o,
    output logic [NUM_LED-1:0] led_o
);

    localparam int SCW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [SCW-1:0] STR_MAX = SCW'(RST_STRETCH - 1);
    localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BCW-1:0] BLINK_MAX = BCW'(BLINK_CYCLES - 1);
    localparam logic [NUM_LED-1:0] LED_ON  = {NUM_LED{LED_BLINK_ON}};
    localparam logic [NUM_LED-1:0] LED_OFF = {NUM_LED{LED_BLINK_OFF}};

    // Reset asserts immediately with arst_i but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst = ~rst_sync_q[1];

    logic [NUM_BTN-1:0] btn_rise_raw;
    logic [NUM_SW-1:0]  sw_rise_unused;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_ch #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (clk_i),
            .rst_i  (rst),
            .raw_i  (btn_i[i]),
            .level_o(btn_o[i]),
            .rise_o (btn_rise_raw[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_ch #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (clk_i),
            .rst_i  (rst),
            .raw_i  (sw_i[i]),
            .level_o(sw_o[i]),
            .rise_o (sw_rise_unused[i])
        );
    end

    logic [1:0]     lock_sync_q;
    logic           lock_s;
    seq_state_e     state_q, state_d;
    logic [SCW-1:0] str_cnt_q, str_cnt_d;
    logic           soc_rst_q, soc_rst_d;
    logic [BCW-1:0] blink_q, blink_d;
    logic [NUM_LED-1:0] led_q, led_d;

    assign lock_s = lock_sync_q[1];

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            lock_sync_q <= '0;
            state_q     <= RST_HOLD;
            str_cnt_q   <= '0;
            soc_rst_q   <= 1'b1;
            blink_q     <= '0;
            led_q       <= LED_ON;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked_i};
            state_q     <= state_d;
            str_cnt_q   <= str_cnt_d;
            soc_rst_q   <= soc_rst_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
        end
    end

    // The cycle in which lock is first seen counts as stretch cycle 1, so
    // release lands exactly 2+RST_STRETCH cycles after the raw lock edge.
    always_comb begin
        state_d   = state_q;
        str_cnt_d = str_cnt_q;
        case (state_q)
            RST_HOLD: begin
                str_cnt_d = '0;
                if (lock_s) begin
                    if (RST_STRETCH == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d   = RST_STRETCH_CNT;
                        str_cnt_d = SCW'(1);
                    end
                end
            end
            RST_STRETCH_CNT: begin
                if (!lock_s) begin
                    state_d   = RST_HOLD;
                    str_cnt_d = '0;
                end else if (str_cnt_q == STR_MAX) begin
                    state_d   = RUN;
                    str_cnt_d = '0;
                end else begin
                    str_cnt_d = str_cnt_q + SCW'(1);
                end
            end
            RUN: begin
                str_cnt_d = '0;
                if (!lock_s) state_d = RST_HOLD;
            end
            default: begin
                state_d   = RST_HOLD;
                str_cnt_d = '0;
            end
        endcase
        soc_rst_d = (state_d != RUN);
    end

    always_comb begin
        blink_d = '0;
        led_d   = led_i;
        if (soc_rst_q) begin
            led_d = led_q;
            if (blink_q == BLINK_MAX) begin
                led_d = (led_q == LED_ON) ? LED_OFF : LED_ON;
            end else begin
                blink_d = blink_q + BCW'(1);
            end
        end
    end

    assign btn_rise_o = btn_rise_raw & {NUM_BTN{~soc_rst_q}};
    assign soc_rst_o  = soc_rst_q;
    assign led_o      = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with short debounce/stretch/blink periods.
module tb_board_io_ctrl;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        pll_locked_i;
    logic [0:0]  btn_i;
    logic [15:0] sw_i;
    logic [15:0] led_i;
    logic [0:0]  btn_o;
    logic [0:0]  btn_rise_o;
    logic [15:0] sw_o;
    logic        soc_rst_o;
    logic [15:0] led_o;

    int n_checks = 0;
    int n_fail   = 0;

    board_io_ctrl #(
        .NUM_BTN(1), .NUM_SW(16), .NUM_LED(16),
        .DEBOUNCE_CYCLES(4), .RST_STRETCH(8), .BLINK_CYCLES(3)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .pll_locked_i(pll_locked_i),
        .btn_i(btn_i), .sw_i(sw_i), .led_i(led_i),
        .btn_o(btn_o), .btn_rise_o(btn_rise_o), .sw_o(sw_o),
        .soc_rst_o(soc_rst_o), .led_o(led_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        arst_i = 1'b1; pll_locked_i = 1'b0; btn_i = '0; sw_i = '0; led_i = '0;
        #3;
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL reset_btn_o got %h want 0", btn_o); end
        n_checks++; if (btn_rise_o !== 1'b0) begin n_fail++; $display("FAIL reset_btn_rise got %h want 0", btn_rise_o); end
        n_checks++; if (sw_o !== 16'h0000) begin n_fail++; $display("FAIL reset_sw_o got %h want 0000", sw_o); end
        n_checks++; if (soc_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_soc_rst got %b want 1", soc_rst_o); end
        n_checks++; if (led_o !== 16'hFFFF) begin n_fail++; $display("FAIL reset_led got %h want ffff", led_o); end
        sw_i = 16'hFFFF;
        repeat (8) tick();
        n_checks++; if (sw_o !== 16'h0000) begin n_fail++; $display("FAIL reset_sw_held got %h want 0000", sw_o); end
        sw_i = '0;
        arst_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_led_blink();
        int waited = 0;
        while (led_o !== 16'h0000 && waited < 12) begin tick(); waited++; end
        n_checks++; if (waited >= 12) begin n_fail++; $display("FAIL blink_first_toggle got timeout want led 0000 within 12 cycles"); end
        tick();
        n_checks++; if (led_o !== 16'h0000) begin n_fail++; $display("FAIL blink_hold1 got %h want 0000", led_o); end
        tick();
        n_checks++; if (led_o !== 16'h0000) begin n_fail++; $display("FAIL blink_hold2 got %h want 0000", led_o); end
        tick();
        n_checks++; if (led_o !== 16'hFFFF) begin n_fail++; $display("FAIL blink_on got %h want ffff", led_o); end
        repeat (3) tick();
        n_checks++; if (led_o !== 16'h0000) begin n_fail++; $display("FAIL blink_off_again got %h want 0000", led_o); end
    endtask

    task automatic test_btn_in_reset();
        logic seen = 1'b0;
        btn_i = 1'b1;
        repeat (6) begin tick(); if (btn_rise_o !== 1'b0) seen = 1'b1; end
        n_checks++; if (btn_o !== 1'b1) begin n_fail++; $display("FAIL inreset_btn_level got %b want 1", btn_o); end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL inreset_rise_gated got %b want 0", seen); end
        btn_i = 1'b0;
        repeat (7) tick();
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL inreset_btn_release got %b want 0", btn_o); end
    endtask

    task automatic test_reset_stretch();
        pll_locked_i = 1'b1;
        repeat (9) tick();
        n_checks++; if (soc_rst_o !== 1'b1) begin n_fail++; $display("FAIL stretch_cycle9 got %b want 1", soc_rst_o); end
        tick();
        n_checks++; if (soc_rst_o !== 1'b0) begin n_fail++; $display("FAIL stretch_cycle10 got %b want 0", soc_rst_o); end
    endtask

    task automatic test_led_passthrough();
        led_i = 16'hA5A5;
        tick();
        n_checks++; if (led_o !== 16'hA5A5) begin n_fail++; $display("FAIL led_pass_a5a5 got %h want a5a5", led_o); end
        led_i = 16'h5A3C;
        tick();
        n_checks++; if (led_o !== 16'h5A3C) begin n_fail++; $display("FAIL led_pass_5a3c got %h want 5a3c", led_o); end
    endtask

    task automatic test_btn_debounce();
        btn_i = 1'b1;
        repeat (5) tick();
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL btn_cycle5 got %b want 0", btn_o); end
        n_checks++; if (btn_rise_o !== 1'b0) begin n_fail++; $display("FAIL btn_rise_cycle5 got %b want 0", btn_rise_o); end
        tick();
        n_checks++; if (btn_o !== 1'b1) begin n_fail++; $display("FAIL btn_cycle6 got %b want 1", btn_o); end
        n_checks++; if (btn_rise_o !== 1'b1) begin n_fail++; $display("FAIL btn_rise_cycle6 got %b want 1", btn_rise_o); end
        tick();
        n_checks++; if (btn_rise_o !== 1'b0) begin n_fail++; $display("FAIL btn_rise_cycle7 got %b want 0", btn_rise_o); end
        n_checks++; if (btn_o !== 1'b1) begin n_fail++; $display("FAIL btn_cycle7 got %b want 1", btn_o); end
    endtask

    task automatic test_btn_release();
        logic seen = 1'b0;
        btn_i = 1'b0;
        repeat (8) begin tick(); if (btn_rise_o !== 1'b0) seen = 1'b1; end
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL release_level got %b want 0", btn_o); end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL release_no_rise got %b want 0", seen); end
    endtask

    task automatic test_sw_glitch();
        logic seen = 1'b0;
        sw_i = 16'h0008;
        repeat (3) tick();
        sw_i = 16'h0000;
        repeat (10) begin tick(); if (sw_o !== 16'h0000) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL sw_glitch_reject got %b want 0", seen); end
        sw_i = 16'h8001;
        repeat (5) tick();
        n_checks++; if (sw_o !== 16'h0000) begin n_fail++; $display("FAIL sw_cycle5 got %h want 0000", sw_o); end
        tick();
        n_checks++; if (sw_o !== 16'h8001) begin n_fail++; $display("FAIL sw_cycle6 got %h want 8001", sw_o); end
    endtask

    task automatic test_lock_loss();
        pll_locked_i = 1'b0;
        repeat (2) tick();
        n_checks++; if (soc_rst_o !== 1'b0) begin n_fail++; $display("FAIL lockloss_cycle2 got %b want 0", soc_rst_o); end
        tick();
        n_checks++; if (soc_rst_o !== 1'b1) begin n_fail++; $display("FAIL lockloss_cycle3 got %b want 1", soc_rst_o); end
        pll_locked_i = 1'b1;
        repeat (9) tick();
        n_checks++; if (soc_rst_o !== 1'b1) begin n_fail++; $display("FAIL relock_cycle9 got %b want 1", soc_rst_o); end
        tick();
        n_checks++; if (soc_rst_o !== 1'b0) begin n_fail++; $display("FAIL relock_cycle10 got %b want 0", soc_rst_o); end
    endtask

    task automatic test_midop_reset();
        logic seen = 1'b0;
        int   waited = 0;
        btn_i = 1'b1;
        repeat (4) tick();
        arst_i = 1'b1;
        #1;
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL midrst_btn got %b want 0", btn_o); end
        n_checks++; if (btn_rise_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rise got %b want 0", btn_rise_o); end
        n_checks++; if (sw_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_sw got %h want 0000", sw_o); end
        n_checks++; if (soc_rst_o !== 1'b1) begin n_fail++; $display("FAIL midrst_soc_rst got %b want 1", soc_rst_o); end
        n_checks++; if (led_o !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_led got %h want ffff", led_o); end
        btn_i = 1'b0;
        sw_i  = 16'h0000;
        repeat (2) tick();
        arst_i = 1'b0;
        while (soc_rst_o !== 1'b0 && waited < 40) begin
            tick(); waited++;
            if (btn_rise_o !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (waited >= 40) begin n_fail++; $display("FAIL midrst_rerun got timeout want soc_rst 0 within 40 cycles"); end
        repeat (8) begin tick(); if (btn_rise_o !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rise got %b want 0", seen); end
        n_checks++; if (btn_o !== 1'b0) begin n_fail++; $display("FAIL midrst_btn_after got %b want 0", btn_o); end
        btn_i = 1'b1;
        repeat (5) tick();
        n_checks++; if (btn_rise_o !== 1'b0) begin n_fail++; $display("FAIL fresh_rise_cycle5 got %b want 0", btn_rise_o); end
        tick();
        n_checks++; if (btn_rise_o !== 1'b1) begin n_fail++; $display("FAIL fresh_rise_cycle6 got %b want 1", btn_rise_o); end
    endtask

    initial begin
        test_reset();
        test_led_blink();
        test_btn_in_reset();
        test_reset_stretch();
        test_led_passthrough();
        test_btn_debounce();
        test_btn_release();
        test_sw_glitch();
        test_lock_loss();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
